// File: rtl/fifo_push_arbiter_if.sv
// ---------------------------------------------------------------------------------------------
// fifo_push_arbiter_if
//
// Bundles the producer-side valid/ready streams and the FIFO-side push/flag signals used by
// fifo_push_arbiter.
//
// Signals:
//   req_valid        [NUM_REQ]         per-producer data valid
//   req_data         [NUM_REQ*DATA_W]  packed producer data, producer i at [i*DATA_W +: DATA_W]
//   req_ready        [NUM_REQ]         per-producer accept (one-hot or zero)
//   fifo_full                          FIFO full flag
//   fifo_almost_full                   FIFO holds DEPTH-1 or more entries
//   fifo_push                          registered push into the FIFO
//   fifo_data        [DATA_W]          registered data into the FIFO
//   grant_id         [clog2(NUM_REQ)]  producer whose beat is on fifo_data
//   burst_active                       high while a producer holds the burst lock
//
// Modports:
//   master - producers plus FIFO flags (drives requests and flags, observes grants)
//   slave  - the arbiter
// ---------------------------------------------------------------------------------------------
interface fifo_push_arbiter_if #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned DATA_W  = 8
);

   localparam int unsigned IdW = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0]        req_ready;
   logic                      fifo_full;
   logic                      fifo_almost_full;
   logic                      fifo_push;
   logic [DATA_W-1:0]         fifo_data;
   logic [IdW-1:0]            grant_id;
   logic                      burst_active;

   modport master (
      output req_valid,
      output req_data,
      output fifo_full,
      output fifo_almost_full,
      input  req_ready,
      input  fifo_push,
      input  fifo_data,
      input  grant_id,
      input  burst_active
   );

   modport slave (
      input  req_valid,
      input  req_data,
      input  fifo_full,
      input  fifo_almost_full,
      output req_ready,
      output fifo_push,
      output fifo_data,
      output grant_id,
      output burst_active
   );

endinterface

// File: rtl/fifo_push_arbiter.sv
// ---------------------------------------------------------------------------------------------
// fifo_push_arbiter
//
// Round-robin write-side scheduler sharing one synchronous FIFO among NUM_REQ producers. One
// producer is accepted per cycle; its word is pushed into the FIFO from a register stage one
// cycle later. A producer that wins may keep the FIFO for up to BURST_LEN consecutive beats
// before the priority pointer rotates past it (BURST_LEN = 1 gives pure round-robin).
//
// Ports:
//   clk     in  clock, rising edge
//   rst     in  asynchronous active-low reset
//   io_bus  slave modport of fifo_push_arbiter_if:
//             req_valid/req_data in, req_ready out (combinational, one-hot or zero)
//             fifo_full/fifo_almost_full in
//             fifo_push/fifo_data/grant_id/burst_active out (registered)
// ---------------------------------------------------------------------------------------------
module fifo_push_arbiter #(
   parameter int unsigned NUM_REQ   = 4,
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned BURST_LEN = 4
) (
   input logic                clk,
   input logic                rst,
   fifo_push_arbiter_if.slave io_bus
);

   localparam int unsigned IdW  = $clog2(NUM_REQ);
   localparam int unsigned CntW = $clog2(BURST_LEN + 1);

   if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
      $error("fifo_push_arbiter: NUM_REQ must be in 2..8");
   end
   if (BURST_LEN < 1) begin : g_bad_burst_len
      $error("fifo_push_arbiter: BURST_LEN must be at least 1");
   end

   typedef enum logic [0:0] {
      StIdle,
      StBurst
   } state_e;

   // ------------------------------------------------------------------------------------------
   // Declarations
   // ------------------------------------------------------------------------------------------
   state_e              r_state;
   state_e              w_state_nxt;
   logic [IdW-1:0]      r_ptr;
   logic [IdW-1:0]      w_ptr_nxt;
   logic [IdW-1:0]      r_lock;
   logic [IdW-1:0]      w_lock_nxt;
   logic [CntW-1:0]     r_cnt;
   logic [CntW-1:0]     w_cnt_nxt;

   logic                r_push;
   logic [DATA_W-1:0]   r_data;
   logic [IdW-1:0]      r_grant;
   logic                r_burst;

   logic [DATA_W-1:0]   w_words [NUM_REQ];
   logic                w_can_accept;
   logic [IdW-1:0]      w_sel;
   logic [IdW-1:0]      w_cand;
   logic                w_sel_valid;
   logic                w_xfer;
   logic [NUM_REQ-1:0]  w_ready;

   // (idx + off) mod NUM_REQ; idx is always a legal index, off < NUM_REQ + 1, so one
   // conditional subtraction keeps the result inside 0..NUM_REQ-1 for any NUM_REQ.
   function automatic logic [IdW-1:0] f_add_wrap(input logic [IdW-1:0] idx,
                                                 input int unsigned    off);
      int unsigned sum;
      sum = 32'(idx) + off;
      if (sum >= NUM_REQ) begin
         sum = sum - NUM_REQ;
      end
      return IdW'(sum);
   endfunction

   // ------------------------------------------------------------------------------------------
   // Producer word unpacking
   // ------------------------------------------------------------------------------------------
   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign w_words[g] = io_bus.req_data[g*DATA_W +: DATA_W];
   end

   // ------------------------------------------------------------------------------------------
   // Capacity: the FIFO flags lag our own registered push by one cycle, so a push in flight
   // into an almost-full FIFO must be treated as filling it.
   // ------------------------------------------------------------------------------------------
   assign w_can_accept = !io_bus.fifo_full && !(r_push && io_bus.fifo_almost_full);

   // ------------------------------------------------------------------------------------------
   // Selection
   // ------------------------------------------------------------------------------------------
   always_comb begin
      w_sel       = r_ptr;
      w_sel_valid = 1'b0;
      w_cand      = '0;
      if (r_state == StBurst) begin
         // Locked producer only; nobody else is considered while the lock is held.
         w_sel       = r_lock;
         w_sel_valid = io_bus.req_valid[r_lock];
      end else begin
         // Walk from the farthest offset to the nearest so the requester closest to the
         // pointer is the last one written, i.e. the winner.
         for (int unsigned k = 0; k < NUM_REQ; k++) begin
            w_cand = f_add_wrap(r_ptr, NUM_REQ - 1 - k);
            if (io_bus.req_valid[w_cand]) begin
               w_sel       = w_cand;
               w_sel_valid = 1'b1;
            end
         end
      end
   end

   assign w_xfer = w_sel_valid && w_can_accept;

   always_comb begin
      w_ready = '0;
      // Nothing may be accepted while reset is held low.
      if (rst && w_xfer) begin
         w_ready[w_sel] = 1'b1;
      end
   end

   // ------------------------------------------------------------------------------------------
   // Lock / pointer state machine
   // ------------------------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_ptr_nxt   = r_ptr;
      w_lock_nxt  = r_lock;
      w_cnt_nxt   = r_cnt;
      unique case (r_state)
         StIdle: begin
            if (w_xfer) begin
               if (BURST_LEN > 1) begin
                  w_state_nxt = StBurst;
                  w_lock_nxt  = w_sel;
                  w_cnt_nxt   = CntW'(1);
               end else begin
                  w_ptr_nxt = f_add_wrap(w_sel, 1);
               end
            end
         end
         StBurst: begin
            if (!io_bus.req_valid[r_lock]) begin
               // Locked producer went quiet: release immediately rather than wait.
               w_state_nxt = StIdle;
               w_ptr_nxt   = f_add_wrap(r_lock, 1);
               w_cnt_nxt   = '0;
            end else if (w_xfer) begin
               if (32'(r_cnt) + 32'd1 >= BURST_LEN) begin
                  w_state_nxt = StIdle;
                  w_ptr_nxt   = f_add_wrap(r_lock, 1);
                  w_cnt_nxt   = '0;
               end else begin
                  w_cnt_nxt = r_cnt + CntW'(1);
               end
            end
            // Valid but back-pressured: hold lock and count.
         end
         default: begin
            w_state_nxt = StIdle;
         end
      endcase
   end

   // ------------------------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= StIdle;
         r_ptr   <= '0;
         r_lock  <= '0;
         r_cnt   <= '0;
         r_push  <= 1'b0;
         r_data  <= '0;
         r_grant <= '0;
         r_burst <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_ptr   <= w_ptr_nxt;
         r_lock  <= w_lock_nxt;
         r_cnt   <= w_cnt_nxt;
         r_push  <= w_xfer;
         r_burst <= (w_state_nxt == StBurst);
         if (w_xfer) begin
            r_data  <= w_words[w_sel];
            r_grant <= w_sel;
         end
      end
   end

   // ------------------------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------------------------
   assign io_bus.req_ready    = w_ready;
   assign io_bus.fifo_push    = r_push;
   assign io_bus.fifo_data    = r_data;
   assign io_bus.grant_id     = r_grant;
   assign io_bus.burst_active = r_burst;

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// ---------------------------------------------------------------------------------------------
// tb_fifo_push_arbiter
//
// Drives two arbiters side by side (BURST_LEN = 1 and BURST_LEN = 4), each with its own set of
// producers and its own 10-deep FIFO occupancy model, and compares every cycle against a
// behavioural reference of the arbitration rules.
// ---------------------------------------------------------------------------------------------
module tb_fifo_push_arbiter;

   localparam int N     = 4;
   localparam int W     = 8;
   localparam int Depth = 10;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   fifo_push_arbiter_if #(.NUM_REQ(N), .DATA_W(W)) bus_rr ();
   fifo_push_arbiter_if #(.NUM_REQ(N), .DATA_W(W)) bus_bl ();

   fifo_push_arbiter #(.NUM_REQ(N), .DATA_W(W), .BURST_LEN(1)) u_rr (
      .clk    (clk),
      .rst    (rst),
      .io_bus (bus_rr.slave)
   );

   fifo_push_arbiter #(.NUM_REQ(N), .DATA_W(W), .BURST_LEN(4)) u_bl (
      .clk    (clk),
      .rst    (rst),
      .io_bus (bus_bl.slave)
   );

   int n_vec = 0;
   int n_err = 0;

   // Stimulus knobs
   logic [N-1:0] mask;
   int           new_pct;
   int           drop_pct;
   int           pop_pct;
   bit           force_full;

   // Producers (index 0: round-robin DUT, index 1: burst DUT)
   logic [N-1:0] p_valid [2];
   logic [W-1:0] p_data  [2][N];

   // FIFO occupancy model
   int fcnt    [2];
   bit f_full  [2];
   bit f_af    [2];
   bit landing [2];

   // Reference model
   int           m_ptr   [2];
   int           m_owner [2];
   int           m_beats [2];
   int           m_gid   [2];
   int           m_acc   [2];
   bit           m_push  [2];
   bit           m_burst [2];
   logic [W-1:0] m_data  [2];
   logic [N-1:0] m_ready [2];

   function automatic int blen(input int d);
      return (d == 0) ? 1 : 4;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_ptr[d]   = 0;
         m_owner[d] = -1;
         m_beats[d] = 0;
         m_gid[d]   = 0;
         m_acc[d]   = -1;
         m_push[d]  = 1'b0;
         m_burst[d] = 1'b0;
         m_data[d]  = '0;
      end
   endtask

   task automatic drive();
      for (int d = 0; d < 2; d++) begin
         p_valid[d] &= mask;
         f_full[d] = force_full || (fcnt[d] >= Depth);
         f_af[d]   = force_full || (fcnt[d] >= Depth - 1);
      end
      bus_rr.req_valid        = p_valid[0];
      bus_bl.req_valid        = p_valid[1];
      for (int i = 0; i < N; i++) begin
         bus_rr.req_data[i*W +: W] = p_data[0][i];
         bus_bl.req_data[i*W +: W] = p_data[1][i];
      end
      bus_rr.fifo_full        = f_full[0];
      bus_rr.fifo_almost_full = f_af[0];
      bus_bl.fifo_full        = f_full[1];
      bus_bl.fifo_almost_full = f_af[1];
   endtask

   // One clock of the reference: who is offered the FIFO, and what gets pushed next.
   task automatic step(input int d);
      int c;
      bit cap;
      c = -1;
      if (m_owner[d] >= 0) begin
         if (p_valid[d][m_owner[d]]) c = m_owner[d];
      end else begin
         for (int k = 0; k < N; k++) begin
            if (c < 0 && p_valid[d][(m_ptr[d] + k) % N]) c = (m_ptr[d] + k) % N;
         end
      end
      cap        = !f_full[d] && !(m_push[d] && f_af[d]);
      m_acc[d]   = (cap && c >= 0) ? c : -1;
      m_ready[d] = '0;
      if (m_acc[d] >= 0) m_ready[d][m_acc[d]] = 1'b1;
      if (m_owner[d] >= 0 && c < 0) begin
         m_ptr[d]   = (m_owner[d] + 1) % N;
         m_owner[d] = -1;
         m_beats[d] = 0;
         m_push[d]  = 1'b0;
      end else if (m_acc[d] >= 0) begin
         m_push[d] = 1'b1;
         m_data[d] = p_data[d][c];
         m_gid[d]  = c;
         if (blen(d) == 1) begin
            m_ptr[d] = (c + 1) % N;
         end else begin
            m_owner[d] = c;
            m_beats[d]++;
            if (m_beats[d] == blen(d)) begin
               m_owner[d] = -1;
               m_beats[d] = 0;
               m_ptr[d]   = (c + 1) % N;
            end
         end
      end else begin
         m_push[d] = 1'b0;
      end
      m_burst[d] = (m_owner[d] >= 0);
   endtask

   // Starts and ends just after a falling edge.
   task automatic cycle();
      drive();
      #1;
      landing[0] = bus_rr.fifo_push;
      landing[1] = bus_bl.fifo_push;
      step(0);
      step(1);
      check("ready_rr", bus_rr.req_ready, m_ready[0]);
      check("ready_bl", bus_bl.req_ready, m_ready[1]);
      @(posedge clk);
      #1;
      check("push_rr",  bus_rr.fifo_push,    m_push[0]);
      check("data_rr",  bus_rr.fifo_data,    m_data[0]);
      check("gid_rr",   bus_rr.grant_id,     m_gid[0]);
      check("burst_rr", bus_rr.burst_active, m_burst[0]);
      check("push_bl",  bus_bl.fifo_push,    m_push[1]);
      check("data_bl",  bus_bl.fifo_data,    m_data[1]);
      check("gid_bl",   bus_bl.grant_id,     m_gid[1]);
      check("burst_bl", bus_bl.burst_active, m_burst[1]);
      for (int d = 0; d < 2; d++) begin
         fcnt[d] += landing[d];
         check("fifo_no_overflow", (fcnt[d] <= Depth), 1);
         if (fcnt[d] > 0 && $urandom_range(99) < pop_pct) fcnt[d]--;
         for (int i = 0; i < N; i++) begin
            if (m_acc[d] == i) begin
               p_valid[d][i] = ($urandom_range(99) < new_pct);
               p_data[d][i]  = W'($urandom);
            end else if (p_valid[d][i]) begin
               if ($urandom_range(99) < drop_pct) p_valid[d][i] = 1'b0;
            end else if ($urandom_range(99) < new_pct) begin
               p_valid[d][i] = 1'b1;
               p_data[d][i]  = W'($urandom);
            end
         end
      end
      @(negedge clk);
   endtask

   // Asynchronous reset pulse between edges; outputs must clear before any clock edge.
   task automatic pulse_reset();
      #1 rst = 1'b0;
      #1;
      check("arst_push_rr",  bus_rr.fifo_push,    0);
      check("arst_data_rr",  bus_rr.fifo_data,    0);
      check("arst_gid_rr",   bus_rr.grant_id,     0);
      check("arst_burst_rr", bus_rr.burst_active, 0);
      check("arst_ready_rr", bus_rr.req_ready,    0);
      check("arst_push_bl",  bus_bl.fifo_push,    0);
      check("arst_data_bl",  bus_bl.fifo_data,    0);
      check("arst_gid_bl",   bus_bl.grant_id,     0);
      check("arst_burst_bl", bus_bl.burst_active, 0);
      check("arst_ready_bl", bus_bl.req_ready,    0);
      #1 rst = 1'b1;
      model_reset();
   endtask

   initial begin
      int guard;
      mask       = '1;
      new_pct    = 100;
      drop_pct   = 0;
      pop_pct    = 100;
      force_full = 1'b0;
      for (int d = 0; d < 2; d++) begin
         fcnt[d]    = 0;
         p_valid[d] = '1;
         for (int i = 0; i < N; i++) p_data[d][i] = W'($urandom);
      end
      model_reset();

      // Reset held with every producer requesting
      rst = 1'b0;
      drive();
      repeat (2) @(posedge clk);
      #1;
      check("rst_push_rr",  bus_rr.fifo_push, 0);
      check("rst_ready_rr", bus_rr.req_ready, 0);
      check("rst_gid_rr",   bus_rr.grant_id,  0);
      check("rst_push_bl",  bus_bl.fifo_push, 0);
      check("rst_ready_bl", bus_bl.req_ready, 0);
      check("rst_gid_bl",   bus_bl.grant_id,  0);
      @(negedge clk);
      rst = 1'b1;
      drive();
      #1;
      check("release_ready_rr", bus_rr.req_ready, 4'b0001);
      check("release_ready_bl", bus_bl.req_ready, 4'b0001);

      // Round-robin with all four valid: grants 0,1,2,3,0
      for (int k = 0; k < 5; k++) begin
         cycle();
         check("rr_seq", bus_rr.grant_id, k % 4);
      end

      // Burst lock between producers 0 and 2
      pulse_reset();
      mask = 4'b0101;
      repeat (20) cycle();

      // Producer 0 drops valid mid-burst after beat 2 -> producer 2 takes over at once
      guard = 0;
      while (!(m_owner[1] == 0 && m_beats[1] == 2) && guard < 40) begin
         cycle();
         guard++;
      end
      check("drop_setup_reached", (guard < 40), 1);
      mask = 4'b0100;
      cycle();
      cycle();
      check("drop_switch_gid", bus_bl.grant_id,     2);
      check("drop_switch_bst", bus_bl.burst_active, 1);

      // Sparse wrap: pointer at 3, only producer 1 valid
      pulse_reset();
      mask = 4'b0100;
      repeat (2) cycle();
      mask = 4'b0010;
      cycle();
      check("wrap_gid", bus_rr.grant_id, 1);
      mask = 4'b0110;
      cycle();
      check("wrap_ptr_gid", bus_rr.grant_id, 2);

      // Throttle: fill the FIFO with no pops, then drain slowly
      mask    = '1;
      pop_pct = 0;
      repeat (30) cycle();
      pop_pct = 40;
      repeat (30) cycle();
      force_full = 1'b1;
      for (int k = 0; k < 4; k++) begin
         cycle();
         check("full_no_push_rr", bus_rr.fifo_push, 0);
         check("full_no_push_bl", bus_bl.fifo_push, 0);
      end
      force_full = 1'b0;
      pop_pct    = 100;
      repeat (5) cycle();

      // Asynchronous reset during beat 2 of a burst, then restart from producer 0
      mask = 4'b0101;
      guard = 0;
      while (m_beats[1] != 2 && guard < 40) begin
         cycle();
         guard++;
      end
      check("beat2_reached", (guard < 40), 1);
      pulse_reset();
      cycle();
      check("restart_gid_bl", bus_bl.grant_id, 0);
      check("restart_gid_rr", bus_rr.grant_id, 0);

      // Randomised traffic
      mask     = '1;
      new_pct  = 60;
      drop_pct = 10;
      pop_pct  = 50;
      repeat (400) cycle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
